// File: rtl/uart_io_pkg.sv
// Shared types and widths for the UART request/done bridge.
package uart_io_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int IO_WORD_W   = 32;

    // Write path: idle, waiting for TX space, reporting completion.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PEND = 2'd1,
        W_DONE = 2'd2
    } wstate_t;

    // Read path: idle, waiting for an RX byte, reporting completion.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DONE = 2'd2
    } rstate_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push into a full FIFO is
// accepted only when a pop happens on the same edge (the pop frees the slot).
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer advance; wrap falls out of the natural binary rollover.
    always_comb begin
        wptr_d = do_push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;
    end

    // Pointer registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_io_bridge.sv
// Responder for the core's UART write/read request-done handshake,
// buffering bytes between the exec stage and the serial PHYs.
module uart_io_bridge
    import uart_io_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   uart_wenable,
    input  logic [IO_WORD_W-1:0]   uart_wd,
    output logic                   uart_wdone,
    input  logic                   uart_renable,
    output logic [IO_WORD_W-1:0]   uart_rd,
    output logic                   uart_rdone,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [UART_BYTE_W-1:0] rx_data,
    input  logic                   rx_valid,
    output logic                   rx_overrun
);
    // TX side
    logic                   tx_full, tx_empty, tx_push, tx_pop;
    logic [UART_BYTE_W-1:0] tx_din;
    // RX side
    logic                   rx_full, rx_empty, rx_pop;
    logic [UART_BYTE_W-1:0] rx_head;
    // FSM state and registered outputs
    wstate_t                wstate_q, wstate_d;
    rstate_t                rstate_q, rstate_d;
    logic [UART_BYTE_W-1:0] wbyte_q, wbyte_d;
    logic [IO_WORD_W-1:0]   rd_q, rd_d;
    logic                   wdone_q, wdone_d;
    logic                   rdone_q, rdone_d;
    logic                   ovr_q, ovr_d;
    // Only the low byte of the write word is ever transmitted.
    logic                   wd_hi_unused;

    assign wd_hi_unused = ^uart_wd[IO_WORD_W-1:UART_BYTE_W];

    assign tx_valid   = !tx_empty;
    assign tx_pop     = tx_valid && tx_ready;
    assign uart_wdone = wdone_q;
    assign uart_rdone = rdone_q;
    assign uart_rd    = rd_q;
    assign rx_overrun = ovr_q;

    io_fifo #(.WIDTH(UART_BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (tx_push),
        .din_i   (tx_din),
        .pop_i   (tx_pop),
        .head_o  (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    io_fifo #(.WIDTH(UART_BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (rx_valid),
        .din_i   (rx_data),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Write FSM next state: push only when TX has space (a same-edge pop
    // does not count), so the TX FIFO never sees a push while full.
    always_comb begin
        wstate_d = wstate_q;
        wbyte_d  = wbyte_q;
        tx_push  = 1'b0;
        tx_din   = uart_wd[UART_BYTE_W-1:0];
        case (wstate_q)
            W_IDLE: begin
                if (uart_wenable) begin
                    if (!tx_full) begin
                        tx_push  = 1'b1;
                        wstate_d = W_DONE;
                    end else begin
                        wbyte_d  = uart_wd[UART_BYTE_W-1:0];
                        wstate_d = W_PEND;
                    end
                end
            end
            W_PEND: begin
                tx_din = wbyte_q;
                if (!tx_full) begin
                    tx_push  = 1'b1;
                    wstate_d = W_DONE;
                end
            end
            W_DONE: begin
                // Leave only once the done pulse has actually been shown.
                if (wdone_q) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read FSM next state: pop only from a non-empty FIFO, no bypass of a
    // byte arriving on the same edge.
    always_comb begin
        rstate_d = rstate_q;
        rd_d     = rd_q;
        rx_pop   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (uart_renable) begin
                    if (!rx_empty) begin
                        rx_pop   = 1'b1;
                        rd_d     = {{(IO_WORD_W-UART_BYTE_W){1'b0}}, rx_head};
                        rstate_d = R_DONE;
                    end else begin
                        rstate_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (!rx_empty) begin
                    rx_pop   = 1'b1;
                    rd_d     = {{(IO_WORD_W-UART_BYTE_W){1'b0}}, rx_head};
                    rstate_d = R_DONE;
                end
            end
            R_DONE:  rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Done arbitration: rdone has priority; a blocked wdone slips one cycle
    // because reads can never produce back-to-back rdone pulses.
    always_comb begin
        rdone_d = (rstate_d == R_DONE);
        wdone_d = (wstate_d == W_DONE) && !rdone_d;
        ovr_d   = ovr_q || (rx_valid && rx_full && !rx_pop);
    end

    // State and registered outputs for both FSMs plus the sticky overrun.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wbyte_q  <= '0;
            rd_q     <= '0;
            wdone_q  <= 1'b0;
            rdone_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wbyte_q  <= wbyte_d;
            rd_q     <= rd_d;
            wdone_q  <= wdone_d;
            rdone_q  <= rdone_d;
            ovr_q    <= ovr_d;
        end
    end

    // A new request while the matching path is busy is a core-side bug.
    a_wr_proto: assert property (@(posedge clk) disable iff (!rstn)
        uart_wenable |-> (wstate_q == W_IDLE));
    a_rd_proto: assert property (@(posedge clk) disable iff (!rstn)
        uart_renable |-> (rstate_q == R_IDLE));

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed plus randomized checks of uart_io_bridge against a queue model.
module tb_uart_io_bridge;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        uart_wenable, uart_renable, uart_wdone, uart_rdone;
    logic [31:0] uart_wd, uart_rd;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_overrun;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          rand_rdy = 1'b0;
    bit          ovr_model = 1'b0;
    logic [7:0]  tx_exp[$];
    logic [7:0]  tx_seen[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  b, first_b;

    always #5 clk = ~clk;

    uart_io_bridge #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_wenable (uart_wenable),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rd      (uart_rd),
        .uart_rdone   (uart_rdone),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record TX handshakes mid-cycle, land #1 after the edge.
    task automatic tick;
        @(negedge clk);
        if (rstn && tx_valid && tx_ready) tx_seen.push_back(tx_data);
        @(posedge clk);
        #1;
        if (uart_wdone || uart_rdone)
            chk("done_collision", 32'(uart_wdone & uart_rdone), 32'd0);
        if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic req_write(logic [7:0] wb);
        uart_wenable = 1'b1;
        uart_wd      = {24'($urandom), wb};
        tick;
        uart_wenable = 1'b0;
    endtask

    task automatic req_read;
        uart_renable = 1'b1;
        tick;
        uart_renable = 1'b0;
    endtask

    // Single-cycle PHY byte; model keeps at most DEPTH bytes, rest dropped.
    task automatic rx_push(logic [7:0] rb);
        rx_valid = 1'b1;
        rx_data  = rb;
        tick;
        rx_valid = 1'b0;
        if (rx_q.size() == DEPTH) ovr_model = 1'b1;
        else rx_q.push_back(rb);
    endtask

    // Read with data already buffered: done in the very next cycle.
    task automatic read_now(string tag);
        req_read;
        chk({tag, "_rdone"}, 32'(uart_rdone), 32'd1);
        chk({tag, "_rd"}, uart_rd, {24'h0, rx_q.pop_front()});
        tick;
    endtask

    // Read on empty RX; byte arrives after d idle cycles, done 2 cycles later.
    task automatic read_wait(int d, logic [7:0] rb, string tag);
        req_read;
        chk({tag, "_early"}, 32'(uart_rdone), 32'd0);
        repeat (d) begin
            tick;
            chk({tag, "_wait"}, 32'(uart_rdone), 32'd0);
        end
        rx_push(rb);
        chk({tag, "_n1"}, 32'(uart_rdone), 32'd0);
        tick;
        chk({tag, "_n2"}, 32'(uart_rdone), 32'd1);
        chk({tag, "_rd"}, uart_rd, {24'h0, rx_q.pop_front()});
        tick;
    endtask

    initial begin
        rstn = 1'b0; uart_wenable = 1'b0; uart_renable = 1'b0; uart_wd = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tick; tick;
        chk("rst_wdone", 32'(uart_wdone), 32'd0);
        chk("rst_rdone", 32'(uart_rdone), 32'd0);
        chk("rst_rd", uart_rd, 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_ovr", 32'(rx_overrun), 32'd0);
        rstn = 1'b1;
        tick;

        // Single write, PHY always ready.
        tx_ready = 1'b1;
        uart_wenable = 1'b1; uart_wd = 32'h0000_0141;
        tick;
        uart_wenable = 1'b0;
        tx_exp.push_back(8'h41);
        chk("t1_wdone", 32'(uart_wdone), 32'd1);
        chk("t1_txv", 32'(tx_valid), 32'd1);
        chk("t1_txd", 32'(tx_data), 32'h41);
        tick;
        chk("t1_wdone_off", 32'(uart_wdone), 32'd0);
        chk("t1_empty", 32'(tx_valid), 32'd0);

        // Fill TX with PHY stalled; 17th write waits for space.
        tx_ready = 1'b0;
        first_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            if (i == 0) first_b = b;
            tx_exp.push_back(b);
            req_write(b);
            chk("t2_wdone", 32'(uart_wdone), 32'd1);
            tick;
        end
        b = 8'($urandom);
        tx_exp.push_back(b);
        req_write(b);
        chk("t2_pend", 32'(uart_wdone), 32'd0);
        repeat (3) begin
            tick;
            chk("t2_stall", 32'(uart_wdone), 32'd0);
        end
        chk("t2_txv", 32'(tx_valid), 32'd1);
        chk("t2_head", 32'(tx_data), 32'(first_b));
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        chk("t2_p1", 32'(uart_wdone), 32'd0);
        tick;
        chk("t2_p2", 32'(uart_wdone), 32'd1);
        tick;
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && tx_valid; k++) tick;
        chk("t2_drained", 32'(tx_valid), 32'd0);

        // Two buffered RX bytes read back in order, read data held.
        rx_push(8'h0A);
        rx_push(8'hFF);
        read_now("t3_a");
        read_now("t3_b");
        chk("t3_idle", 32'(uart_rdone), 32'd0);
        chk("t3_hold", uart_rd, 32'h0000_00FF);

        // Read waits on empty RX; byte shows up 5 cycles after the request.
        read_wait(4, 8'h55, "t4");

        // Simultaneous requests: rdone first, wdone one cycle later.
        rx_push(8'h33);
        uart_wenable = 1'b1; uart_wd = {24'($urandom), 8'h77};
        uart_renable = 1'b1;
        tick;
        uart_wenable = 1'b0; uart_renable = 1'b0;
        tx_exp.push_back(8'h77);
        chk("t5_rdone", 32'(uart_rdone), 32'd1);
        chk("t5_wdone_defer", 32'(uart_wdone), 32'd0);
        chk("t5_rd", uart_rd, {24'h0, rx_q.pop_front()});
        tick;
        chk("t5_wdone", 32'(uart_wdone), 32'd1);
        chk("t5_rdone_off", 32'(uart_rdone), 32'd0);
        tick;
        chk("t5_wdone_off", 32'(uart_wdone), 32'd0);

        // RX overrun: 17 bytes into a 16-entry FIFO.
        for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom_range(1, 255)));
        chk("t6_no_ovr", 32'(rx_overrun), 32'd0);
        rx_push(8'($urandom));
        chk("t6_ovr", 32'(rx_overrun), 32'(ovr_model));
        for (int i = 0; i < DEPTH; i++) read_now("t6_rd");
        chk("t6_ovr_sticky", 32'(rx_overrun), 32'd1);

        // Reset while a write is pending on a full TX FIFO.
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            req_write(8'($urandom));
            tick;
        end
        req_write(8'($urandom));
        chk("t6_pend", 32'(uart_wdone), 32'd0);
        tick;
        rstn = 1'b0;
        tick;
        chk("t6_rst_wdone", 32'(uart_wdone), 32'd0);
        chk("t6_rst_rdone", 32'(uart_rdone), 32'd0);
        chk("t6_rst_rd", uart_rd, 32'd0);
        chk("t6_rst_txv", 32'(tx_valid), 32'd0);
        chk("t6_rst_ovr", 32'(rx_overrun), 32'd0);
        rstn = 1'b1;
        ovr_model = 1'b0;
        rx_q.delete();
        tx_ready = 1'b1;
        repeat (3) begin
            tick;
            chk("t6_no_late_wdone", 32'(uart_wdone), 32'd0);
            chk("t6_tx_empty", 32'(tx_valid), 32'd0);
        end

        // Random mix of writes, reads and PHY bytes with a jittery TX PHY.
        rand_rdy = 1'b1;
        for (int it = 0; it < 90; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    b = 8'($urandom);
                    tx_exp.push_back(b);
                    req_write(b);
                    for (int k = 0; k < 60 && !uart_wdone; k++) tick;
                    chk("rnd_wdone", 32'(uart_wdone), 32'd1);
                    tick;
                end
                1: begin
                    if (rx_q.size() > 0) read_now("rnd_rd");
                    else read_wait($urandom_range(0, 3), 8'($urandom), "rnd_rw");
                end
                default: begin
                    rx_push(8'($urandom));
                    chk("rnd_ovr", 32'(rx_overrun), 32'(ovr_model));
                end
            endcase
        end

        // Drain TX and compare the PHY byte stream with what was written.
        rand_rdy = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 60 && tx_valid; k++) tick;
        tick;
        chk("tx_count", 32'(tx_seen.size()), 32'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
            chk("tx_byte", 32'(tx_seen[i]), 32'(tx_exp[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
